kvadd2_example_burst_requester: RTL and testbench
=================================================

KVADD2_EXAMPLE_BURST_REQUESTER -- requirements
Module: kvadd2_example_burst_requester

Interface
REQ-001 The module SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter C_ADDR_WIDTH, default 64, SHALL set the address width in bits.
REQ-003 Parameter C_XFER_SIZE_WIDTH, default 32, SHALL set the width of the transfer byte count.
REQ-004 Parameter C_DATA_BYTES, default 64, SHALL set the bytes per data beat (power of 2).
REQ-005 Parameter C_BURST_BEATS, default 64, SHALL set the maximum beats per burst (power of 2, 1..256).
REQ-006 Parameter C_MAX_OUTSTANDING, default 16, SHALL set the maximum number of unanswered bursts (1..255).
REQ-007 Ports SHALL be:
- aclk  in  1  clock.
- areset_n  in  1  synchronous active-low reset.
- ctrl_start  in  1  start pulse, sampled only in IDLE.
- ctrl_addr_offset  in  C_ADDR_WIDTH  base byte address.
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  total bytes to transfer.
- ctrl_done  out  1  one-cycle completion pulse.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready.
- araddr  out  C_ADDR_WIDTH  burst start address.
- arlen  out  8  beats minus one.
- rlast_hs  in  1  one-cycle pulse per completed burst (rvalid & rready & rlast).
- protocol_err  out  1  sticky error flag.

Function
REQ-008 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-009 In IDLE, ctrl_start=1 at cycle N SHALL latch the offset and size and move to ISSUE at N+1; ctrl_start outside IDLE SHALL be ignored.
REQ-010 Total beats SHALL be ceil(size / C_DATA_BYTES); the burst count SHALL be ceil(beats / C_BURST_BEATS); each burst SHALL have C_BURST_BEATS beats except the last, which carries the remainder.
REQ-011 araddr for burst k SHALL be offset + k*C_BURST_BEATS*C_DATA_BYTES, with the low log2(C_DATA_BYTES) offset bits forced to zero; bursts are not split at 4 KB, and callers align the offset to C_BURST_BEATS*C_DATA_BYTES.
REQ-012 arlen SHALL equal the burst beat count minus one.
REQ-013 Issue rules:
- arvalid SHALL be registered.
- Once arvalid is asserted, arvalid, araddr and arlen SHALL hold stable until arvalid & arready.
- arvalid SHALL only rise when the outstanding count is below C_MAX_OUTSTANDING.
REQ-014 A handshake on the last burst SHALL deassert arvalid in the next cycle and move ISSUE to DRAIN.
REQ-015 The outstanding counter:
- SHALL increment on an address handshake.
- SHALL decrement on rlast_hs.
- SHALL hold when both occur in the same cycle.
REQ-016 DRAIN SHALL move to DONE in the cycle after the outstanding count reaches zero; ctrl_done SHALL be 1 for exactly that DONE cycle, and the FSM SHALL return to IDLE in the next cycle.
REQ-017 size=0 SHALL pass ISSUE→DRAIN→DONE with no arvalid; ctrl_done SHALL assert at N+3.
REQ-018 rlast_hs while the count is zero SHALL leave the count at zero and set protocol_err, which SHALL stay set until reset.
REQ-019 The transfer size SHALL be unlimited within C_XFER_SIZE_WIDTH; the burst index counter SHALL be wide enough to avoid wrap-around.

Reset
REQ-020 While areset_n=0 at a clock edge, the following SHALL apply at the next cycle:
- The FSM SHALL be in IDLE.
- arvalid, ctrl_done and protocol_err SHALL be 0.
- The outstanding count SHALL be 0.
- araddr and arlen SHALL be 0.
REQ-021 Reset mid-transfer SHALL abandon all pending bursts without completing the handshake, and no ctrl_done SHALL follow.

Verification
REQ-022 The bench SHALL cover these scenarios (C_DATA_BYTES=64, C_BURST_BEATS=64):
- offset=0x1000, size=8192, arready=1 -> two bursts: araddr 0x1000 then 0x2000, arlen 63 each; ctrl_done one cycle after the second rlast_hs has brought the count to 0.
- size=100 -> one burst, arlen=1; done after one rlast_hs.
- size=0 -> no arvalid; ctrl_done pulses at N+3.
- C_MAX_OUTSTANDING=2, size=20480, no rlast_hs -> exactly 2 handshakes, then arvalid=0; one rlast_hs -> third burst issued; hold arready=0 for 5 cycles -> araddr and arlen stable.
- Address handshake and rlast_hs in the same cycle with count=1 -> count stays 1; rlast_hs with count=0 -> protocol_err=1 until reset.
- areset_n=0 during ISSUE with arvalid=1 -> arvalid=0, count=0, FSM in IDLE next cycle; a new ctrl_start is accepted normally.

Source files
------------

// File: rtl/kvadd2_example_burst_requester.sv
// AXI-style read-address burst requester: splits a byte transfer into
// fixed-size bursts and tracks outstanding bursts until all complete.
module kvadd2_example_burst_requester #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_DATA_BYTES      = 64,
  parameter int unsigned C_BURST_BEATS     = 64,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [C_ADDR_WIDTH-1:0]      araddr,
  output logic [7:0]                   arlen,
  input  logic                         rlast_hs,
  output logic                         protocol_err
);

  localparam int unsigned AW  = C_ADDR_WIDTH;
  localparam int unsigned XW  = C_XFER_SIZE_WIDTH;
  localparam int unsigned LDB = $clog2(C_DATA_BYTES);
  localparam int unsigned LBB = $clog2(C_BURST_BEATS);
  localparam int unsigned CW  = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int unsigned BURST_BYTES = C_BURST_BEATS * C_DATA_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t         r_state;
  logic           r_arvalid;
  logic [AW-1:0]  r_araddr;
  logic [7:0]     r_arlen;
  logic           r_done;
  logic           r_perr;
  logic [CW-1:0]  r_out_cnt;
  logic [AW-1:0]  r_next_addr;
  logic [XW-1:0]  r_bursts;
  logic [XW-1:0]  r_idx;
  logic [7:0]     r_last_len;

  logic [XW-1:0]  w_beats;
  logic [XW-1:0]  w_bursts;
  logic [XW-1:0]  w_beat_rem;
  logic [7:0]     w_last_len;
  logic           w_ar_hs;
  logic [CW-1:0]  w_cnt_next;
  logic [XW-1:0]  w_idx_next;
  logic           w_more;
  logic           w_is_last;
  logic           w_room;

  // Ceil divisions: size -> beats -> bursts; the last burst takes the remainder.
  assign w_beats = (ctrl_xfer_size_in_bytes >> LDB)
    + XW'(|(ctrl_xfer_size_in_bytes & XW'(C_DATA_BYTES - 1)));
  assign w_beat_rem = w_beats & XW'(C_BURST_BEATS - 1);
  assign w_bursts = (w_beats >> LBB) + XW'(|w_beat_rem);
  assign w_last_len = (w_beat_rem == '0)
    ? 8'(C_BURST_BEATS - 1) : 8'(w_beat_rem - XW'(1));

  assign w_ar_hs    = r_arvalid & arready;
  assign w_idx_next = r_idx + XW'(w_ar_hs);
  assign w_more     = w_idx_next < r_bursts;
  assign w_is_last  = w_idx_next == (r_bursts - XW'(1));
  assign w_room     = w_cnt_next < CW'(C_MAX_OUTSTANDING);

  always_comb begin
    w_cnt_next = r_out_cnt;
    if (w_ar_hs && !rlast_hs)
      w_cnt_next = r_out_cnt + CW'(1);
    else if (!w_ar_hs && rlast_hs && r_out_cnt != '0)
      w_cnt_next = r_out_cnt - CW'(1);
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state     <= IDLE;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_out_cnt   <= '0;
      r_next_addr <= '0;
      r_bursts    <= '0;
      r_idx       <= '0;
      r_last_len  <= '0;
    end else begin
      r_out_cnt <= w_cnt_next;
      r_done    <= 1'b0;
      if (rlast_hs && r_out_cnt == '0)
        r_perr <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (ctrl_start) begin
            r_next_addr <= ctrl_addr_offset & ~AW'(C_DATA_BYTES - 1);
            r_bursts    <= w_bursts;
            r_last_len  <= w_last_len;
            r_idx       <= '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_idx <= w_idx_next;
          // A new request may be presented once the current one is taken.
          if (!r_arvalid || w_ar_hs) begin
            if (!w_more) begin
              r_arvalid <= 1'b0;
              r_state   <= DRAIN;
            end else if (w_room) begin
              r_arvalid   <= 1'b1;
              r_araddr    <= r_next_addr;
              r_arlen     <= w_is_last ? r_last_len
                                       : 8'(C_BURST_BEATS - 1);
              r_next_addr <= r_next_addr + AW'(BURST_BYTES);
            end else begin
              r_arvalid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (w_cnt_next == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign arvalid      = r_arvalid;
  assign araddr       = r_araddr;
  assign arlen        = r_arlen;
  assign ctrl_done    = r_done;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_kvadd2_example_burst_requester.sv
// Scoreboard bench for the burst requester: expected AR beats and
// ctrl_done cycles are queued by stimulus and checked by a monitor.
module tb_kvadd2_example_burst_requester;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [63:0] ctrl_addr_offset = '0;
  logic [31:0] ctrl_xfer_size_in_bytes = '0;
  logic        ctrl_done;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic        rlast_hs = 1'b0;
  logic        protocol_err;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t exp_ar[$];
  int  exp_done[$];
  int  cyc = 0;
  int  hs_cnt = 0;
  int  checks = 0;
  int  errors = 0;

  kvadd2_example_burst_requester #(
    .C_ADDR_WIDTH(64),
    .C_XFER_SIZE_WIDTH(32),
    .C_DATA_BYTES(64),
    .C_BURST_BEATS(64),
    .C_MAX_OUTSTANDING(2)
  ) dut (
    .aclk(clk),
    .areset_n(areset_n),
    .ctrl_start(ctrl_start),
    .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_done(ctrl_done),
    .arvalid(arvalid),
    .arready(arready),
    .araddr(araddr),
    .arlen(arlen),
    .rlast_hs(rlast_hs),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (arvalid && arready) begin
      ar_t e;
      hs_cnt++;
      if (exp_ar.size() == 0) begin
        chk("ar_unexpected", araddr, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        e = exp_ar.pop_front();
        chk("araddr", araddr, e.addr);
        chk("arlen", 64'(arlen), 64'(e.len));
      end
    end
    if (ctrl_done) begin
      if (exp_done.size() == 0)
        chk("done_unexpected", 64'(cyc), 64'hFFFF_FFFF);
      else
        chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_xfer(input logic [63:0] off, input logic [31:0] sz,
                            output int n);
    ctrl_addr_offset = off;
    ctrl_xfer_size_in_bytes = sz;
    ctrl_start = 1'b1;
    n = cyc;
    step();
    ctrl_start = 1'b0;
  endtask

  task automatic pulse_rlast(output int r);
    rlast_hs = 1'b1;
    r = cyc;
    step();
    rlast_hs = 1'b0;
  endtask

  task automatic push_ar(input logic [63:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len = l;
    exp_ar.push_back(e);
  endtask

  task automatic wait_arvalid(input string name);
    int i;
    for (i = 0; i < 10; i++) begin
      if (arvalid) break;
      step();
    end
    chk(name, 64'(arvalid), 64'd1);
  endtask

  initial begin
    int n, r, hs0;
    steps(2);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_done", 64'(ctrl_done), 64'd0);
    chk("rst_perr", 64'(protocol_err), 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    chk("rst_cnt", 64'(dut.r_out_cnt), 64'd0);
    areset_n = 1'b1;
    step();

    // Two full bursts from 0x1000.
    arready = 1'b1;
    push_ar(64'h1000, 8'd63);
    push_ar(64'h2000, 8'd63);
    start_xfer(64'h1000, 32'd8192, n);
    steps(4);
    pulse_rlast(r);
    pulse_rlast(r);
    exp_done.push_back(r + 1);
    steps(4);

    // Single short burst; misaligned low bits dropped.
    push_ar(64'h4000, 8'd1);
    start_xfer(64'h4013, 32'd100, n);
    steps(2);
    pulse_rlast(r);
    exp_done.push_back(r + 1);
    steps(4);

    // Zero-length transfer.
    start_xfer(64'h8000, 32'd0, n);
    exp_done.push_back(n + 3);
    steps(5);

    // Outstanding limit of 2, five bursts.
    for (int k = 0; k < 5; k++)
      push_ar(64'h10000 + 64'(k) * 64'h1000, 8'd63);
    hs0 = hs_cnt;
    start_xfer(64'h10000, 32'd20480, n);
    steps(8);
    chk("limit_hs", 64'(hs_cnt - hs0), 64'd2);
    chk("limit_arvalid", 64'(arvalid), 64'd0);
    arready = 1'b0;
    pulse_rlast(r);
    for (int k = 0; k < 5; k++) begin
      chk("stall_arvalid", 64'(arvalid), 64'd1);
      chk("stall_araddr", araddr, 64'h12000);
      chk("stall_arlen", 64'(arlen), 64'd63);
      step();
    end
    arready = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      steps(2);
      pulse_rlast(r);
    end
    exp_done.push_back(r + 1);
    steps(4);
    chk("limit_perr", 64'(protocol_err), 64'd0);

    // Simultaneous AR handshake and rlast_hs, then a stray rlast_hs.
    arready = 1'b0;
    push_ar(64'h0, 8'd63);
    push_ar(64'h1000, 8'd63);
    start_xfer(64'h0, 32'd8192, n);
    wait_arvalid("same_wait1");
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("same_cnt1", 64'(dut.r_out_cnt), 64'd1);
    chk("same_arvalid2", 64'(arvalid), 64'd1);
    arready = 1'b1;
    rlast_hs = 1'b1;
    step();
    arready = 1'b0;
    rlast_hs = 1'b0;
    chk("same_cnt_hold", 64'(dut.r_out_cnt), 64'd1);
    chk("same_arvalid_off", 64'(arvalid), 64'd0);
    pulse_rlast(r);
    exp_done.push_back(r + 1);
    steps(3);
    chk("pre_perr", 64'(protocol_err), 64'd0);
    pulse_rlast(r);
    chk("stray_perr", 64'(protocol_err), 64'd1);
    chk("stray_cnt", 64'(dut.r_out_cnt), 64'd0);
    steps(5);
    chk("perr_sticky", 64'(protocol_err), 64'd1);

    // Reset during ISSUE with arvalid high.
    start_xfer(64'h20000, 32'd20480, n);
    wait_arvalid("rst_wait");
    areset_n = 1'b0;
    step();
    areset_n = 1'b1;
    chk("mid_arvalid", 64'(arvalid), 64'd0);
    chk("mid_cnt", 64'(dut.r_out_cnt), 64'd0);
    chk("mid_state", 64'(dut.r_state), 64'd0);
    chk("mid_perr", 64'(protocol_err), 64'd0);
    chk("mid_araddr", araddr, 64'd0);
    steps(3);
    arready = 1'b1;
    push_ar(64'h3000, 8'd1);
    start_xfer(64'h3000, 32'd100, n);
    steps(2);
    pulse_rlast(r);
    exp_done.push_back(r + 1);
    steps(6);

    chk("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
